// File: rtl/spi_master_ctrl_if.sv
// Request/response and SPI wire signals of spi_master_ctrl, grouped with
// controller-side (master) and environment-side (slave) modports.
interface spi_master_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    modport master (
        input  tx_data, tx_last, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
    );

    modport slave (
        output tx_data, tx_last, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-3 single-chip-select SPI master, one byte per request, CS_N held until a last byte.
// Optional build macro SPI_MASTER_CTRL_MSB_FIRST_EN selects MSB-first bit order (default LSB-first).
module spi_master_ctrl #(
    parameter int CLK_DIV = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    spi_master_ctrl_if.master bus
);
    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_byte;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_next;
    logic             last_q;
    logic             accept;
    logic             div_end;

    // Wire position of the n-th transferred bit within a byte.
    function automatic logic [2:0] bit_idx(input logic [2:0] n);
`ifdef SPI_MASTER_CTRL_MSB_FIRST_EN
        return 3'd7 - n;
`else
        return n;
`endif
    endfunction

    assign accept  = (state == IDLE) && bus.tx_valid && bus.tx_ready;
    assign div_end = (div_cnt == DIV_LAST);

    always_comb begin
        rx_next                   = rx_shift;
        rx_next[bit_idx(bit_cnt)] = bus.miso;
    end

    // Payload registers carry no reset; they are only read after an accept.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tx_byte <= bus.tx_data;
            last_q  <= bus.tx_last;
        end
        if (state == LOW && div_end) begin
            rx_shift <= rx_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            bus.sclk     <= 1'b1;
            bus.mosi     <= 1'b0;
            bus.cs_n     <= 1'b1;
            bus.tx_ready <= 1'b1;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
            bus.busy     <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.cs_n     <= 1'b0;
                        bus.mosi     <= bus.tx_data[bit_idx(3'd0)];
                        bus.tx_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        bit_cnt      <= '0;
                        div_cnt      <= '0;
                        state        <= HIGH;
                    end
                end
                HIGH: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        bus.sclk <= 1'b0;
                        state    <= LOW;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        bus.sclk <= 1'b1;
                        if (bit_cnt == 3'd7) begin
                            bus.rx_data  <= rx_next;
                            bus.rx_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            bus.mosi <= tx_byte[bit_idx(bit_cnt + 3'd1)];
                            state    <= HIGH;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // A byte without the last flag keeps the slave selected.
                    bus.cs_n     <= last_q;
                    bus.mosi     <= 1'b0;
                    bus.tx_ready <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
